// File: rtl/flow_stat_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : flow_stat_rd_arbiter_if
// Purpose  : Bundles the requester-side and conveyor-side signals of the
//            flow statistics read arbiter.
// Ports    : slave  - arbiter view (requests/read data in, grants/responses/
//                     strobe out)
//            master - environment view (requesters plus conveyor)
// Revision : 1.0 - initial release
// ============================================================================
interface flow_stat_rd_arbiter_if #(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 32,
  parameter int N_REQ   = 4
);
  // Requester side
  logic [N_REQ-1:0]         req_i;
  logic [N_REQ*A_WIDTH-1:0] req_flow_i;
  logic [N_REQ-1:0]         gnt_o;
  logic [N_REQ-1:0]         rsp_val_o;
  logic [D_WIDTH-1:0]       rsp_data_o;
  logic                     rsp_err_o;
  logic                     busy_o;
  // Conveyor side
  logic                     rd_stb_o;
  logic [A_WIDTH-1:0]       rd_flow_num_o;
  logic [D_WIDTH-1:0]       rd_data_i;
  logic                     rd_data_val_i;

  modport slave (
    input  req_i, req_flow_i, rd_data_i, rd_data_val_i,
    output gnt_o, rsp_val_o, rsp_data_o, rsp_err_o, busy_o,
           rd_stb_o, rd_flow_num_o
  );

  modport master (
    output req_i, req_flow_i, rd_data_i, rd_data_val_i,
    input  gnt_o, rsp_val_o, rsp_data_o, rsp_err_o, busy_o,
           rd_stb_o, rd_flow_num_o
  );
endinterface
`default_nettype wire

// File: rtl/flow_stat_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : flow_stat_rd_arbiter
// Purpose  : Round-robin arbiter sharing the conveyor's single read-and-clear
//            port between N_REQ requesters, one outstanding read at a time.
// Ports    : clk_i, rst_i   - clock, synchronous active-high reset
//            bus (slave)    - req_i/req_flow_i in, gnt_o/rsp_val_o/rsp_data_o/
//                             rsp_err_o/busy_o out; rd_stb_o/rd_flow_num_o out,
//                             rd_data_i/rd_data_val_i in
// Options  : FSRA_TIMEOUT_EN - enables the RSP_TIMEOUT WAIT-state watchdog;
//            when undefined WAIT lasts until a valid and rsp_err_o is 0.
// Revision : 1.0 - initial release
// ============================================================================
module flow_stat_rd_arbiter #(
  parameter int A_WIDTH     = 10,
  parameter int D_WIDTH     = 32,
  parameter int N_REQ       = 4,
  parameter int RSP_TIMEOUT = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  flow_stat_rd_arbiter_if.slave bus
);

  localparam int                c_PW           = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [c_PW-1:0]   c_LAST         = c_PW'(N_REQ - 1);
  localparam logic [c_PW:0]     c_NREQ         = (c_PW + 1)'(N_REQ);
  localparam logic [N_REQ-1:0]  c_ONE          = N_REQ'(1);
  localparam logic [7:0]        c_TIMEOUT_LAST = 8'(RSP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_PW-1:0]    r_ptr;
  logic [c_PW-1:0]    r_win;
  logic               r_blank;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_rsp_val;
  logic [D_WIDTH-1:0] r_rsp_data;
  logic               r_rd_stb;
  logic [A_WIDTH-1:0] r_rd_flow;
  logic               r_busy;

  // Per-requester flow numbers unpacked for indexing by winner
  logic [A_WIDTH-1:0] w_flow_arr [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_flow
    assign w_flow_arr[g] = bus.req_flow_i[g*A_WIDTH +: A_WIDTH];
  end

  // Round-robin pick: first set request at or above the pointer, wrapping
  logic            w_any;
  logic [c_PW-1:0] w_win;
  logic [c_PW:0]   w_sum;
  logic [c_PW-1:0] w_idx;

  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_sum = '0;
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (c_PW + 1)'(i);
      if (w_sum >= c_NREQ) w_sum = w_sum - c_NREQ;
      w_idx = w_sum[c_PW-1:0];
      if (!w_any && bus.req_i[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

`ifdef FSRA_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_rsp_err;
`else
  logic       w_unused_timeout;
  assign w_unused_timeout = ^c_TIMEOUT_LAST;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_win      <= '0;
      r_blank    <= 1'b0;
      r_gnt      <= '0;
      r_rsp_val  <= '0;
      r_rsp_data <= '0;
      r_rd_stb   <= 1'b0;
      r_rd_flow  <= '0;
      r_busy     <= 1'b0;
`ifdef FSRA_TIMEOUT_EN
      r_cnt      <= '0;
      r_rsp_err  <= 1'b0;
`endif
    end else begin
      // Single-cycle pulses default low
      r_gnt     <= '0;
      r_rd_stb  <= 1'b0;
      r_rsp_val <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win     <= w_win;
            r_rd_flow <= w_flow_arr[w_win];
            r_gnt     <= c_ONE << w_win;
            r_rd_stb  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_ptr   <= (r_win == c_LAST) ? '0 : r_win + 1'b1;
          r_blank <= 1'b1;
`ifdef FSRA_TIMEOUT_EN
          r_cnt   <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // The blanking cycle skips a valid level left over from the last read
          if (!r_blank && bus.rd_data_val_i) begin
            r_rsp_data <= bus.rd_data_i;
            r_rsp_val  <= c_ONE << r_win;
`ifdef FSRA_TIMEOUT_EN
            r_rsp_err  <= 1'b0;
`endif
            r_state    <= S_RESP;
          end
`ifdef FSRA_TIMEOUT_EN
          else if (r_cnt == c_TIMEOUT_LAST) begin
            r_rsp_data <= '0;
            r_rsp_val  <= c_ONE << r_win;
            r_rsp_err  <= 1'b1;
            r_state    <= S_RESP;
          end
`endif
          else begin
            r_blank <= 1'b0;
`ifdef FSRA_TIMEOUT_EN
            r_cnt   <= r_cnt + 8'd1;
`endif
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt_o         = r_gnt;
  assign bus.rsp_val_o     = r_rsp_val;
  assign bus.rsp_data_o    = r_rsp_data;
  assign bus.rd_stb_o      = r_rd_stb;
  assign bus.rd_flow_num_o = r_rd_flow;
  assign bus.busy_o        = r_busy;
`ifdef FSRA_TIMEOUT_EN
  assign bus.rsp_err_o     = r_rsp_err;
`else
  assign bus.rsp_err_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flow_stat_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_flow_stat_rd_arbiter
// Purpose  : Directed self-checking bench for flow_stat_rd_arbiter.
// Options  : FSRA_TIMEOUT_EN selects the timeout expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flow_stat_rd_arbiter;
  localparam int A_WIDTH     = 10;
  localparam int D_WIDTH     = 32;
  localparam int N_REQ       = 4;
  localparam int RSP_TIMEOUT = 15;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  flow_stat_rd_arbiter_if #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .N_REQ(N_REQ)) bus ();

  flow_stat_rd_arbiter #(
    .A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .N_REQ(N_REQ), .RSP_TIMEOUT(RSP_TIMEOUT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_flows(input logic [A_WIDTH-1:0] f0, f1, f2, f3);
    bus.req_flow_i = {f3, f2, f1, f0};
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    bus.req_i = '0;
    bus.rd_data_val_i = 1'b0;
    bus.rd_data_i = '0;
    tick;
    tick;
    rst_i = 1'b0;
  endtask

  // One complete read: waits (bounded) for the grant, returns data in the
  // second WAIT cycle and checks grant, response and return to idle.
  task automatic run_read(input logic [N_REQ-1:0] exp_gnt, input logic [A_WIDTH-1:0] exp_flow,
                          input logic [D_WIDTH-1:0] data,
                          input logic [N_REQ-1:0] req_after_gnt, input logic [N_REQ-1:0] req_after_rsp);
    int k;
    k = 0;
    while (bus.gnt_o === '0 && k < 20) begin
      tick;
      k++;
    end
    n_vec++;
    if (bus.gnt_o !== exp_gnt || bus.rd_stb_o !== 1'b1 || bus.rd_flow_num_o !== exp_flow || bus.busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL grant: gnt=%b stb=%b flow=%0d busy=%b, required gnt=%b stb=1 flow=%0d busy=1",
               bus.gnt_o, bus.rd_stb_o, bus.rd_flow_num_o, bus.busy_o, exp_gnt, exp_flow);
    end
    bus.req_i = req_after_gnt;
    bus.rd_data_val_i = 1'b0;
    tick;                           // blanking WAIT cycle
    bus.rd_data_val_i = 1'b1;
    bus.rd_data_i = data;
    tick;                           // second WAIT cycle
    n_vec++;
    if (bus.gnt_o !== '0 || bus.rd_stb_o !== 1'b0 || bus.rsp_val_o !== '0 || bus.busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL wait: gnt=%b stb=%b rsp_val=%b busy=%b, required 0000 0 0000 1",
               bus.gnt_o, bus.rd_stb_o, bus.rsp_val_o, bus.busy_o);
    end
    tick;                           // RESP
    n_vec++;
    if (bus.rsp_val_o !== exp_gnt || bus.rsp_data_o !== data || bus.rsp_err_o !== 1'b0) begin
      n_err++;
      $display("FAIL resp: rsp_val=%b data=%h err=%b, required %b %h 0",
               bus.rsp_val_o, bus.rsp_data_o, bus.rsp_err_o, exp_gnt, data);
    end
    bus.req_i = req_after_rsp;
    tick;                           // IDLE
    n_vec++;
    if (bus.rsp_val_o !== '0 || bus.busy_o !== 1'b0 || bus.rsp_data_o !== data) begin
      n_err++;
      $display("FAIL idle: rsp_val=%b busy=%b data=%h, required 0000 0 %h",
               bus.rsp_val_o, bus.busy_o, bus.rsp_data_o, data);
    end
  endtask

  task automatic test_reset;
    do_reset;
    n_vec++;
    if ({bus.gnt_o, bus.rsp_val_o, bus.rsp_data_o, bus.rsp_err_o, bus.rd_stb_o, bus.rd_flow_num_o, bus.busy_o} !== '0) begin
      n_err++;
      $display("FAIL reset: gnt=%b rsp_val=%b data=%h err=%b stb=%b flow=%0d busy=%b, required all 0",
               bus.gnt_o, bus.rsp_val_o, bus.rsp_data_o, bus.rsp_err_o, bus.rd_stb_o, bus.rd_flow_num_o, bus.busy_o);
    end
  endtask

  task automatic test_single_read;
    do_reset;
    set_flows(10'd3, 10'd0, 10'd0, 10'd0);
    bus.req_i = 4'b0001;
    tick;
    n_vec++;
    if (bus.gnt_o !== 4'b0001 || bus.rd_stb_o !== 1'b1 || bus.rd_flow_num_o !== 10'd3 || bus.busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_grant: gnt=%b stb=%b flow=%0d busy=%b, required 0001 1 3 1",
               bus.gnt_o, bus.rd_stb_o, bus.rd_flow_num_o, bus.busy_o);
    end
    bus.req_i = '0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_vec++;
      if (bus.rsp_val_o !== '0 || bus.gnt_o !== '0 || bus.rd_stb_o !== 1'b0) begin
        n_err++;
        $display("FAIL single_wait%0d: rsp_val=%b gnt=%b stb=%b, required 0000 0000 0",
                 i, bus.rsp_val_o, bus.gnt_o, bus.rd_stb_o);
      end
    end
    bus.rd_data_val_i = 1'b1;
    bus.rd_data_i = 32'h2A;
    tick;
    n_vec++;
    if (bus.rsp_val_o !== 4'b0001 || bus.rsp_data_o !== 32'h2A || bus.rsp_err_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_resp: rsp_val=%b data=%h err=%b, required 0001 0000002a 0",
               bus.rsp_val_o, bus.rsp_data_o, bus.rsp_err_o);
    end
    bus.rd_data_val_i = 1'b0;
    tick;
    n_vec++;
    if (bus.rsp_val_o !== '0 || bus.busy_o !== 1'b0 || bus.rsp_data_o !== 32'h2A) begin
      n_err++;
      $display("FAIL single_idle: rsp_val=%b busy=%b data=%h, required 0000 0 0000002a",
               bus.rsp_val_o, bus.busy_o, bus.rsp_data_o);
    end
  endtask

  task automatic test_round_robin;
    do_reset;
    set_flows(10'd0, 10'd1, 10'd2, 10'd3);
    bus.req_i = 4'b1111;
    run_read(4'b0001, 10'd0, 32'd100, 4'b1111, 4'b1111);
    run_read(4'b0010, 10'd1, 32'd101, 4'b1111, 4'b1111);
    run_read(4'b0100, 10'd2, 32'd102, 4'b1111, 4'b1111);
    run_read(4'b1000, 10'd3, 32'd103, 4'b1111, 4'b1111);
    run_read(4'b0001, 10'd0, 32'd104, 4'b0000, 4'b0000);
  endtask

  task automatic test_sticky_valid;
    do_reset;
    set_flows(10'd0, 10'd7, 10'd0, 10'd0);
    bus.rd_data_val_i = 1'b1;       // stale level from an earlier read
    bus.rd_data_i = 32'hAA;
    bus.req_i = 4'b0010;
    tick;
    n_vec++;
    if (bus.gnt_o !== 4'b0010 || bus.rd_flow_num_o !== 10'd7) begin
      n_err++;
      $display("FAIL sticky_grant: gnt=%b flow=%0d, required 0010 7", bus.gnt_o, bus.rd_flow_num_o);
    end
    bus.req_i = '0;
    tick;
    tick;                           // stale valid seen only in ISSUE and blanking
    n_vec++;
    if (bus.rsp_val_o !== '0) begin
      n_err++;
      $display("FAIL sticky_blank: rsp_val=%b, required 0000", bus.rsp_val_o);
    end
    bus.rd_data_val_i = 1'b0;
    tick;
    n_vec++;
    if (bus.rsp_val_o !== '0 || bus.busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL sticky_low: rsp_val=%b busy=%b, required 0000 1", bus.rsp_val_o, bus.busy_o);
    end
    bus.rd_data_val_i = 1'b1;
    bus.rd_data_i = 32'h5;
    tick;
    n_vec++;
    if (bus.rsp_val_o !== 4'b0010 || bus.rsp_data_o !== 32'h5) begin
      n_err++;
      $display("FAIL sticky_resp: rsp_val=%b data=%h, required 0010 00000005", bus.rsp_val_o, bus.rsp_data_o);
    end
    bus.rd_data_val_i = 1'b0;
    tick;
  endtask

  task automatic test_withdrawal;
    do_reset;
    set_flows(10'd20, 10'd21, 10'd22, 10'd23);
    bus.req_i = 4'b1101;
    // Requester 2 drops during requester 0's RESP, just before its turn
    run_read(4'b0001, 10'd20, 32'h11, 4'b1100, 4'b1000);
    run_read(4'b1000, 10'd23, 32'h33, 4'b0000, 4'b0000);
  endtask

  task automatic test_back_to_back;
    do_reset;
    set_flows(10'd40, 10'd41, 10'd42, 10'd43);
    bus.req_i = 4'b1000;
    run_read(4'b1000, 10'd43, 32'hB0, 4'b1000, 4'b1000);
    run_read(4'b1000, 10'd43, 32'hB1, 4'b1000, 4'b1001);
    // Pointer wrapped to 0 after requester 3
    run_read(4'b0001, 10'd40, 32'hB2, 4'b0000, 4'b0000);
  endtask

  task automatic test_reset_mid_wait;
    do_reset;
    set_flows(10'd50, 10'd51, 10'd52, 10'd53);
    bus.req_i = 4'b0010;
    tick;
    n_vec++;
    if (bus.gnt_o !== 4'b0010) begin
      n_err++;
      $display("FAIL rstwait_grant: gnt=%b, required 0010", bus.gnt_o);
    end
    bus.req_i = '0;
    tick;
    bus.rd_data_val_i = 1'b1;
    bus.rd_data_i = 32'h77;
    tick;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    n_vec++;
    if ({bus.gnt_o, bus.rsp_val_o, bus.rsp_data_o, bus.rsp_err_o, bus.rd_stb_o, bus.rd_flow_num_o, bus.busy_o} !== '0) begin
      n_err++;
      $display("FAIL rstwait_outputs: gnt=%b rsp_val=%b data=%h stb=%b flow=%0d busy=%b, required all 0",
               bus.gnt_o, bus.rsp_val_o, bus.rsp_data_o, bus.rd_stb_o, bus.rd_flow_num_o, bus.busy_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_vec++;
      if (bus.rsp_val_o !== '0 || bus.busy_o !== 1'b0) begin
        n_err++;
        $display("FAIL rstwait_norsp%0d: rsp_val=%b busy=%b, required 0000 0", i, bus.rsp_val_o, bus.busy_o);
      end
    end
    bus.rd_data_val_i = 1'b0;
    bus.req_i = 4'b0101;
    run_read(4'b0001, 10'd50, 32'hC0, 4'b0000, 4'b0000);
  endtask

  task automatic test_timeout;
    do_reset;
    set_flows(10'd60, 10'd0, 10'd0, 10'd0);
    bus.req_i = 4'b0001;
    run_read(4'b0001, 10'd60, 32'h1234, 4'b0001, 4'b0001);
    tick;
    n_vec++;
    if (bus.gnt_o !== 4'b0001) begin
      n_err++;
      $display("FAIL tmo_grant: gnt=%b, required 0001", bus.gnt_o);
    end
    bus.req_i = '0;
    bus.rd_data_val_i = 1'b0;
`ifdef FSRA_TIMEOUT_EN
    for (int i = 0; i < RSP_TIMEOUT; i++) begin
      tick;
      n_vec++;
      if (bus.rsp_val_o !== '0 || bus.busy_o !== 1'b1) begin
        n_err++;
        $display("FAIL tmo_wait%0d: rsp_val=%b busy=%b, required 0000 1", i, bus.rsp_val_o, bus.busy_o);
      end
    end
    tick;
    n_vec++;
    if (bus.rsp_val_o !== 4'b0001 || bus.rsp_err_o !== 1'b1 || bus.rsp_data_o !== '0) begin
      n_err++;
      $display("FAIL tmo_resp: rsp_val=%b err=%b data=%h, required 0001 1 00000000",
               bus.rsp_val_o, bus.rsp_err_o, bus.rsp_data_o);
    end
    // Valid in the very cycle the timeout fires takes priority
    bus.req_i = 4'b0001;
    tick;
    tick;
    bus.req_i = '0;
    for (int i = 0; i < RSP_TIMEOUT; i++) tick;
    bus.rd_data_val_i = 1'b1;
    bus.rd_data_i = 32'h9;
    tick;
    n_vec++;
    if (bus.rsp_val_o !== 4'b0001 || bus.rsp_err_o !== 1'b0 || bus.rsp_data_o !== 32'h9) begin
      n_err++;
      $display("FAIL tmo_race: rsp_val=%b err=%b data=%h, required 0001 0 00000009",
               bus.rsp_val_o, bus.rsp_err_o, bus.rsp_data_o);
    end
    bus.rd_data_val_i = 1'b0;
    tick;
`else
    for (int i = 0; i < 40; i++) begin
      tick;
      n_vec++;
      if (bus.rsp_val_o !== '0 || bus.busy_o !== 1'b1 || bus.rsp_err_o !== 1'b0) begin
        n_err++;
        $display("FAIL notmo_wait%0d: rsp_val=%b busy=%b err=%b, required 0000 1 0",
                 i, bus.rsp_val_o, bus.busy_o, bus.rsp_err_o);
      end
    end
    do_reset;
`endif
  endtask

  initial begin
    bus.req_i = '0;
    bus.req_flow_i = '0;
    bus.rd_data_i = '0;
    bus.rd_data_val_i = 1'b0;
    test_reset;
    test_single_read;
    test_round_robin;
    test_sticky_valid;
    test_withdrawal;
    test_back_to_back;
    test_reset_mid_wait;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
